// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin arbiter sharing the sideband TX wrapper between NUM_REQ training FSMs.
// Optional watchdog enabled by defining SB_ARB_TIMEOUT_EN.
module sb_tx_msg_arbiter #(
  parameter int unsigned SB_MSG_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH     = 5,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*SB_MSG_WIDTH-1:0]  i_req_msg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic                             i_sb_busy,
  output logic                             o_sb_valid,
  output logic [SB_MSG_WIDTH-1:0]          o_sb_msg,
  output logic [DATA_WIDTH-1:0]            o_sb_data,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic [NUM_REQ-1:0]               o_req_done,
  output logic                             o_timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  state_e             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_inc;
  logic               busy_d;
  logic               busy_fall;
  logic               to_expire;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  logic [SB_MSG_WIDTH-1:0] req_msg_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   req_data_a [NUM_REQ];

  // Unpack the flat requester buses into per-requester fields
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_msg_a[g]  = i_req_msg[g*SB_MSG_WIDTH +: SB_MSG_WIDTH];
    assign req_data_a[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy_fall = busy_d & ~i_sb_busy;
  assign owner_inc = (32'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);

  // Round-robin scan starting at rr_ptr, wrapping past the top requester
  always_comb begin
    int unsigned j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && i_req_valid[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

`ifdef SB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign to_expire = ((state == ST_SEND) || (state == ST_BUSY)) &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in SEND/BUSY; zero whenever outside them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt        <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      o_timeout_err <= to_expire;
      if ((state == ST_SEND) || (state == ST_BUSY)) to_cnt <= to_cnt + TO_W'(1);
      else                                          to_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign to_expire          = 1'b0;
  assign o_timeout_err      = 1'b0;
`endif

  // Arbitration FSM with registered wrapper-side outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      busy_d     <= 1'b0;
      o_sb_valid <= 1'b0;
      o_sb_msg   <= '0;
      o_sb_data  <= '0;
      o_grant    <= '0;
      o_req_done <= '0;
    end else begin
      busy_d     <= i_sb_busy;
      o_req_done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            owner      <= win_idx;
            o_sb_msg   <= req_msg_a[win_idx];
            o_sb_data  <= req_data_a[win_idx];
            o_grant    <= NUM_REQ'(1) << win_idx;
            o_sb_valid <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND, ST_BUSY: begin
          if (to_expire) begin
            o_sb_valid <= 1'b0;
            o_grant    <= '0;
            rr_ptr     <= owner_inc;
            state      <= ST_GAP;
          end else if (state == ST_SEND) begin
            // Busy takes priority: once the wrapper accepts, the send is committed
            if (i_sb_busy) begin
              state <= ST_BUSY;
            end else if (!i_req_valid[owner]) begin
              o_sb_valid <= 1'b0;
              o_grant    <= '0;
              state      <= ST_IDLE;
            end
          end else if (busy_fall) begin
            o_sb_valid <= 1'b0;
            o_req_done <= NUM_REQ'(1) << owner;
            rr_ptr     <= owner_inc;
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          o_grant <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Bench for sb_tx_msg_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_sb_tx_msg_arbiter;

  localparam int unsigned MW = 4;
  localparam int unsigned DW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 15;

  typedef logic [14:0] obs_t;

  typedef struct {
    logic [1:0] rv;
    logic       busy;
    logic       ev;
    logic [1:0] eg;
    logic [1:0] ed;
    logic [3:0] em;
    logic [4:0] edat;
  } vec_t;

  logic              i_clk;
  logic              i_rst_n;
  logic [NR-1:0]     i_req_valid;
  logic [NR*MW-1:0]  i_req_msg;
  logic [NR*DW-1:0]  i_req_data;
  logic              i_sb_busy;
  logic              o_sb_valid;
  logic [MW-1:0]     o_sb_msg;
  logic [DW-1:0]     o_sb_data;
  logic [NR-1:0]     o_grant;
  logic [NR-1:0]     o_req_done;
  logic              o_timeout_err;

  logic [1:0]        rv;
  logic              busy;
  logic [3:0]        rmsg [2];
  logic [4:0]        rdat [2];
  obs_t              obs;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  int         m_owner;
  int         m_dead;
  int         m_ptr;
  bit         m_valid;
  bit         m_commit;
  logic [3:0] m_msg;
  logic [4:0] m_data;
  logic [1:0] m_done;
  bit         pb;

  sb_tx_msg_arbiter #(
    .SB_MSG_WIDTH  (MW),
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_msg    (i_req_msg),
    .i_req_data   (i_req_data),
    .i_sb_busy    (i_sb_busy),
    .o_sb_valid   (o_sb_valid),
    .o_sb_msg     (o_sb_msg),
    .o_sb_data    (o_sb_data),
    .o_grant      (o_grant),
    .o_req_done   (o_req_done),
    .o_timeout_err(o_timeout_err)
  );

  assign i_req_valid = rv;
  assign i_sb_busy   = busy;
  assign i_req_msg   = {rmsg[1], rmsg[0]};
  assign i_req_data  = {rdat[1], rdat[0]};
  assign obs         = {o_sb_valid, o_grant, o_req_done, o_sb_msg, o_sb_data, o_timeout_err};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic obs_t mk(input logic v, input logic [1:0] g, input logic [1:0] d,
                              input logic [3:0] m, input logic [4:0] dt, input logic e);
    return {v, g, d, m, dt, e};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h  {valid,grant,done,msg,data,err}", name, got, want);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    rv      = 2'b00;
    busy    = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_state", obs, '0);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output logic [1:0] g);
    g = 2'b00;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_grant != 2'b00) begin
        g = o_grant;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output logic [1:0] d);
    d = 2'b00;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_req_done != 2'b00) begin
        d = o_req_done;
        break;
      end
    end
  endtask

  // Transaction-level model: grant, commit on busy, complete on busy fall, then dead time
  task automatic model_step(input logic [1:0] r, input logic bsy);
    m_done = 2'b00;
    if (m_dead > 0) begin
      if (m_dead == 2) m_owner = -1;
      m_dead--;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 2; i++) begin
        int k;
        k = (m_ptr + i) % 2;
        if (m_owner < 0 && r[k]) begin
          m_owner  = k;
          m_valid  = 1'b1;
          m_commit = 1'b0;
          m_msg    = rmsg[k];
          m_data   = rdat[k];
        end
      end
    end else if (m_commit) begin
      if (pb && !bsy) begin
        m_done[m_owner] = 1'b1;
        m_valid  = 1'b0;
        m_commit = 1'b0;
        m_ptr    = (m_owner + 1) % 2;
        m_dead   = 2;
      end
    end else if (bsy) begin
      m_commit = 1'b1;
    end else if (!r[m_owner]) begin
      m_owner = -1;
      m_valid = 1'b0;
    end
    pb = bsy;
  endtask

  function automatic obs_t model_obs();
    logic [1:0] g;
    g = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    return mk(m_valid, g, m_done, m_msg, m_data, 1'b0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [$];
    logic [1:0] g;
    logic [1:0] d;
    int         cnt;
    int         dones;

    i_rst_n = 1'b0;
    rv      = 2'b00;
    busy    = 1'b0;
    rmsg[0] = 4'h1;
    rdat[0] = 5'b00010;
    rmsg[1] = 4'h7;
    rdat[1] = 5'b10101;

    // rv, busy -> valid, grant, done, msg, data
    tbl.push_back('{2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 4'h1, 5'b00010});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 4'h1, 5'b00010});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b11, 1'b0, 1'b1, 2'b10, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b01, 1'b1, 1'b1, 2'b10, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 2'b10, 2'b10, 4'h7, 5'b10101});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 4'h7, 5'b10101});
    tbl.push_back('{2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 2'b01, 2'b01, 4'h1, 5'b00010});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'h1, 5'b00010});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 4'h1, 5'b00010});

    // Directed table: single request, abort, pointer hold, committed withdrawal
    do_reset();
    foreach (tbl[i]) begin
      rv   = tbl[i].rv;
      busy = tbl[i].busy;
      @(negedge i_clk);
      check($sformatf("table[%0d]", i), obs,
            mk(tbl[i].ev, tbl[i].eg, tbl[i].ed, tbl[i].em, tbl[i].edat, 1'b0));
    end

    // Contention: both requesting from reset release, alternating grants
    i_rst_n = 1'b0;
    busy    = 1'b0;
    rv      = 2'b11;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_grant(10, g);
      check($sformatf("contention_grant[%0d]", r), obs_t'(g),
            obs_t'((r % 2 == 0) ? 2'b01 : 2'b10));
      busy = 1'b1;
      @(negedge i_clk);
      busy = 1'b0;
      wait_done(5, d);
      check($sformatf("contention_done[%0d]", r), obs_t'(d), obs_t'(g));
    end
    rv = 2'b00;
    repeat (4) @(negedge i_clk);

    // Busy already high when the request arrives
    do_reset();
    busy = 1'b1;
    @(negedge i_clk);
    rv    = 2'b01;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_req_done != 2'b00) dones++;
    end
    check("busyidle_no_early_done", obs_t'(dones), obs_t'(0));
    check("busyidle_granted", obs, mk(1'b1, 2'b01, 2'b00, 4'h1, 5'b00010, 1'b0));
    busy = 1'b0;
    @(negedge i_clk);
    check("busyidle_done", obs, mk(1'b0, 2'b01, 2'b01, 4'h1, 5'b00010, 1'b0));
    rv    = 2'b00;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_req_done != 2'b00) dones++;
    end
    check("busyidle_single_done", obs_t'(dones), obs_t'(0));

    // Asynchronous reset while committed
    do_reset();
    rv = 2'b01;
    @(negedge i_clk);
    busy = 1'b1;
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check("reset_async", obs, '0);
    @(negedge i_clk);
    busy    = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("reset_regrant", obs, mk(1'b1, 2'b01, 2'b00, 4'h1, 5'b00010, 1'b0));
    rv = 2'b00;
    repeat (3) @(negedge i_clk);

`ifdef SB_ARB_TIMEOUT_EN
    // Watchdog: busy never rises, owner is dropped and the other requester served
    do_reset();
    rv    = 2'b11;
    cnt   = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_req_done != 2'b00) dones++;
      if (o_timeout_err) break;
      if (o_sb_valid) cnt++;
    end
    check("timeout_pulse", obs, mk(1'b0, 2'b00, 2'b00, 4'h1, 5'b00010, 1'b1));
    check("timeout_valid_cycles", obs_t'(cnt), obs_t'(TO));
    check("timeout_no_done", obs_t'(dones), obs_t'(0));
    wait_grant(10, g);
    check("timeout_next_owner", obs_t'(g), obs_t'(2'b10));
    rv = 2'b00;
    repeat (20) @(negedge i_clk);
`else
    // Randomized traffic against the reference model
    do_reset();
    m_owner  = -1;
    m_dead   = 0;
    m_ptr    = 0;
    m_valid  = 1'b0;
    m_commit = 1'b0;
    m_msg    = 4'h0;
    m_data   = 5'h00;
    m_done   = 2'b00;
    pb       = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (busy) begin
        if ($urandom_range(3) == 0) busy = 1'b0;
      end else if ((o_sb_valid && $urandom_range(2) == 0) || $urandom_range(24) == 0) begin
        busy = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          if (o_req_done[k]) rv[k] = 1'b0;
          else if (o_grant[k] && o_sb_valid && !busy && $urandom_range(7) == 0) rv[k] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rv[k]   = 1'b1;
          rmsg[k] = 4'($urandom);
          rdat[k] = 5'($urandom);
        end
      end
      model_step(rv, busy);
      @(negedge i_clk);
      check("random", obs, model_obs());
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
